radio_sample_packer: RTL and testbench

- Upstream feeder for the simple_fifo AXI-lite peripheral.
- Takes the radio datapath's strobed 16-bit I/Q samples and applies a programmable decimation.
- Packs each kept sample as {I,Q} into one 32-bit word and pushes it into the FIFO write port.
- Holds one word while the FIFO is full; samples that cannot be stored are counted as drops, never silently lost.

---
 rtl/radio_pack_pkg.sv | 29 ++
 rtl/radio_decimator.sv | 49 ++++
 rtl/radio_sample_packer.sv | 185 ++++++++++++++++++
 tb/tb_radio_sample_packer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : radio_pack_pkg
//  Description : Shared types, default widths and the I/Q packing helper for
//                the radio sample packer and its decimator.
//  Revision    : 1.0  initial release
// ============================================================================
package radio_pack_pkg;

    localparam int SAMPLE_W_DEF   = 16;
    localparam int DECIM_W_DEF    = 8;
    localparam int DROP_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pack_state_t;

    // In-phase component occupies the upper half of the FIFO word.
    function automatic logic [2*SAMPLE_W_DEF-1:0] pack_iq(
        input logic [SAMPLE_W_DEF-1:0] i,
        input logic [SAMPLE_W_DEF-1:0] q
    );
        return {i, q};
    endfunction

endpackage
`default_nettype wire

// File: rtl/radio_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : radio_decimator
//  Description : Keeps one of every decim+1 accepted strobes. The period
//                length is captured from decim on each kept strobe, so a new
//                decim value only takes effect once the running period wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module radio_decimator
    import radio_pack_pkg::*;
#(
    parameter int DECIM_W = DECIM_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active,
    input  logic               strobe,
    input  logic [DECIM_W-1:0] decim,
    output logic               kept
);

    logic [DECIM_W-1:0] count;
    logic [DECIM_W-1:0] period;

    // A strobe is kept when it opens a new period.
    assign kept = active && strobe && (count == '0);

    // Period counter: cleared while inactive, latches the period on each kept strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            period <= '0;
        end else if (!active) begin
            count  <= '0;
            period <= '0;
        end else if (strobe) begin
            if (count == '0) begin
                period <= decim;
                count  <= (decim == '0) ? '0 : DECIM_W'(1);
            end else if (count == period) begin
                count  <= '0;
            end else begin
                count  <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/radio_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : radio_sample_packer
//  Description : Decimates strobed I/Q samples, packs them as {I,Q} and
//                writes them to a FIFO. One word is held while the FIFO is
//                full; kept samples that cannot be stored are counted as
//                drops (saturating) and flag a sticky overflow.
//                Optional macro RADIO_PACK_TEST_PATTERN_EN adds a test_mode
//                input that replaces the data with an incrementing counter
//                starting at 1.
//  Revision    : 1.0  initial release
// ============================================================================
module radio_sample_packer
    import radio_pack_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int DECIM_W    = DECIM_W_DEF,
    parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
`ifdef RADIO_PACK_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic [DECIM_W-1:0]    decim,
    input  logic                  clear_stats,
    input  logic                  sample_strobe,
    input  logic [SAMPLE_W-1:0]   sample_i,
    input  logic [SAMPLE_W-1:0]   sample_q,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [2*SAMPLE_W-1:0] fifo_wr_data,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  overflow,
    output logic                  busy
);

    pack_state_t           state;
    pack_state_t           state_next;
    logic [2*SAMPLE_W-1:0] hold_word;
    logic [2*SAMPLE_W-1:0] new_word;
    logic [2*SAMPLE_W-1:0] sel_word;
    logic [2*SAMPLE_W-1:0] out_word;
    logic                  kept;
    logic                  active;
    logic                  emit_new;
    logic                  emit_hold;
    logic                  load_hold;
    logic                  drop;
    logic                  emit;

    assign active = (state != IDLE);
    assign busy   = active;
    assign emit   = emit_new || emit_hold;

    // Strobes coinciding with enable low are ignored entirely.
    radio_decimator #(
        .DECIM_W (DECIM_W)
    ) u_decimator (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .active (active),
        .strobe (sample_strobe && enable),
        .decim  (decim),
        .kept   (kept)
    );

    if (SAMPLE_W == SAMPLE_W_DEF) begin : g_pack_pkg
        assign new_word = pack_iq(sample_i, sample_q);
    end else begin : g_pack_cat
        assign new_word = {sample_i, sample_q};
    end

    assign sel_word = emit_hold ? hold_word : new_word;

`ifdef RADIO_PACK_TEST_PATTERN_EN
    logic [2*SAMPLE_W-1:0] pattern;

    assign out_word = test_mode ? pattern : sel_word;

    // Test pattern advances only on words written while in test mode.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pattern <= (2*SAMPLE_W)'(1);
        end else if (emit && test_mode) begin
            pattern <= pattern + 1'b1;
        end
    end
`else
    assign out_word = sel_word;
`endif

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle datapath decisions; fifo_full gates every write.
    always_comb begin
        state_next = state;
        emit_new   = 1'b0;
        emit_hold  = 1'b0;
        load_hold  = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (kept) begin
                    if (!fifo_full) begin
                        emit_new = 1'b1;
                    end else begin
                        load_hold  = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!fifo_full) begin
                    emit_hold = 1'b1;
                    if (kept) begin
                        load_hold = 1'b1;
                    end else begin
                        state_next = enable ? RUN : IDLE;
                    end
                end else if (kept) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Hold register captures a kept word that could not be written this cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_word <= '0;
        end else if (load_hold) begin
            hold_word <= new_word;
        end
    end

    // Registered FIFO write port: single-cycle write pulse with its data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= emit;
            if (emit) begin
                fifo_wr_data <= out_word;
            end
        end
    end

    // Drop statistics; a clear in the same cycle as a drop wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_stats) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_radio_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radio_sample_packer
//  Description : Directed self-checking bench for radio_sample_packer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_radio_sample_packer;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        enable;
    logic [7:0]  decim;
    logic        clear_stats;
    logic        sample_strobe;
    logic [15:0] sample_i;
    logic [15:0] sample_q;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [15:0] drop_count;
    logic        overflow;
    logic        busy;
`ifdef RADIO_PACK_TEST_PATTERN_EN
    logic        test_mode;
`endif

    int checks = 0;
    int errors = 0;

    radio_sample_packer dut (
`ifdef RADIO_PACK_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .enable        (enable),
        .decim         (decim),
        .clear_stats   (clear_stats),
        .sample_strobe (sample_strobe),
        .sample_i      (sample_i),
        .sample_q      (sample_q),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .drop_count    (drop_count),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 ACLK = ~ACLK;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples sit 1ns after the rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q);
        sample_i      = i;
        sample_q      = q;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    logic [15:0] kept_i [3];
    int          nwr;

    initial begin
        ARESETN       = 1'b0;
        enable        = 1'b0;
        decim         = 8'd0;
        clear_stats   = 1'b0;
        sample_strobe = 1'b0;
        sample_i      = '0;
        sample_q      = '0;
        fifo_full     = 1'b0;
`ifdef RADIO_PACK_TEST_PATTERN_EN
        test_mode     = 1'b0;
`endif
        tick();
        tick();
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_data",  64'(fifo_wr_data), 64'd0);
        check("rst_drop",  64'(drop_count), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        #2 ARESETN = 1'b1;
        tick();

        // Strobes while disabled are ignored.
        send(16'h1234, 16'h5678);
        check("idle_no_wr", 64'(fifo_wr_en), 64'd0);
        enable = 1'b1;
        tick();
        check("run_busy", 64'(busy), 64'd1);

        // decim=0: every strobe written one cycle later.
        send(16'h0001, 16'hFFFF);
        check("t1_wr0", 64'(fifo_wr_en), 64'd1);
        check("t1_d0",  64'(fifo_wr_data), 64'h0001FFFF);
        tick();
        check("t1_pulse", 64'(fifo_wr_en), 64'd0);
        send(16'h0002, 16'hFFFE);
        check("t1_wr1", 64'(fifo_wr_en), 64'd1);
        check("t1_d1",  64'(fifo_wr_data), 64'h0002FFFE);
        check("t1_drop", 64'(drop_count), 64'd0);

        // decim=3: 12 back-to-back strobes keep I=0,4,8.
        decim = 8'd3;
        nwr = 0;
        for (int k = 0; k < 3; k++) kept_i[k] = 16'hFFFF;
        for (int k = 0; k < 12; k++) begin
            sample_i      = 16'(k);
            sample_q      = 16'h0;
            sample_strobe = 1'b1;
            tick();
            if (fifo_wr_en) begin
                if (nwr < 3) kept_i[nwr] = fifo_wr_data[31:16];
                nwr++;
            end
        end
        sample_strobe = 1'b0;
        check("t2_nwr", 64'(nwr), 64'd3);
        check("t2_i0", 64'(kept_i[0]), 64'd0);
        check("t2_i1", 64'(kept_i[1]), 64'd4);
        check("t2_i2", 64'(kept_i[2]), 64'd8);
        decim = 8'd0;
        tick();

        // FIFO full across three kept strobes: one held, two dropped.
        fifo_full = 1'b1;
        send(16'h0005, 16'h0050);
        check("t3_no_wr", 64'(fifo_wr_en), 64'd0);
        send(16'h0006, 16'h0060);
        send(16'h0007, 16'h0070);
        check("t3_no_wr_full", 64'(fifo_wr_en), 64'd0);
        check("t3_drop", 64'(drop_count), 64'd2);
        check("t3_ovf",  64'(overflow), 64'd1);
        fifo_full = 1'b0;
        tick();
        check("t3_flush_wr", 64'(fifo_wr_en), 64'd1);
        check("t3_flush_d",  64'(fifo_wr_data), 64'h00050050);
        tick();
        check("t3_once", 64'(fifo_wr_en), 64'd0);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("t3_clr_drop", 64'(drop_count), 64'd0);
        check("t3_clr_ovf",  64'(overflow), 64'd0);

        // HOLD with FIFO freeing in the same cycle as a kept strobe.
        fifo_full = 1'b1;
        send(16'h0008, 16'h0008);
        fifo_full = 1'b0;
        send(16'h0009, 16'h0009);
        check("t4_wr_a", 64'(fifo_wr_en), 64'd1);
        check("t4_d_a",  64'(fifo_wr_data), 64'h00080008);
        tick();
        check("t4_wr_b", 64'(fifo_wr_en), 64'd1);
        check("t4_d_b",  64'(fifo_wr_data), 64'h00090009);
        check("t4_drop", 64'(drop_count), 64'd0);
        tick();
        check("t4_idle_wr", 64'(fifo_wr_en), 64'd0);

        // clear_stats coincident with a drop: clear wins.
        fifo_full = 1'b1;
        send(16'h000A, 16'h000A);
        clear_stats = 1'b1;
        send(16'h000B, 16'h000B);
        clear_stats = 1'b0;
        check("t5_clr_drop", 64'(drop_count), 64'd0);
        check("t5_clr_ovf",  64'(overflow), 64'd0);
        send(16'h000C, 16'h000C);
        check("t5_drop1", 64'(drop_count), 64'd1);
        fifo_full = 1'b0;
        tick();
        check("t5_flush_d", 64'(fifo_wr_data), 64'h000A000A);
        tick();

        // enable falls while holding: strobe ignored, word flushed, then IDLE.
        fifo_full = 1'b1;
        send(16'h000D, 16'h000D);
        enable = 1'b0;
        send(16'h000E, 16'h000E);
        check("t6_no_drop", 64'(drop_count), 64'd1);
        check("t6_busy",    64'(busy), 64'd1);
        fifo_full = 1'b0;
        tick();
        check("t6_flush_wr", 64'(fifo_wr_en), 64'd1);
        check("t6_flush_d",  64'(fifo_wr_data), 64'h000D000D);
        check("t6_idle",     64'(busy), 64'd0);

        // Drop counter saturation.
        enable = 1'b1;
        tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        fifo_full = 1'b1;
        send(16'h0020, 16'h0020);
        sample_strobe = 1'b1;
        repeat (65535) tick();
        check("t7_sat", 64'(drop_count), 64'hFFFF);
        tick();
        sample_strobe = 1'b0;
        check("t7_sat_hold", 64'(drop_count), 64'hFFFF);
        check("t7_ovf", 64'(overflow), 64'd1);

        // Asynchronous reset while in HOLD, checked before the next edge.
        #2 ARESETN = 1'b0;
        #1;
        check("t8_wr_en", 64'(fifo_wr_en), 64'd0);
        check("t8_busy",  64'(busy), 64'd0);
        check("t8_drop",  64'(drop_count), 64'd0);
        check("t8_ovf",   64'(overflow), 64'd0);
        #2 ARESETN = 1'b1;
        tick();
        fifo_full = 1'b0;
        enable    = 1'b1;
        decim     = 8'd0;
`ifdef RADIO_PACK_TEST_PATTERN_EN
        test_mode = 1'b1;
`endif
        tick();
        for (int k = 1; k <= 4; k++) begin
            send(16'(16'h0030 + k), 16'(16'h0040 + k));
            check("t8_wr", 64'(fifo_wr_en), 64'd1);
`ifdef RADIO_PACK_TEST_PATTERN_EN
            check("t8_pat", 64'(fifo_wr_data), 64'(k));
`else
            check("t8_iq", 64'(fifo_wr_data), 64'({16'(16'h0030 + k), 16'(16'h0040 + k)}));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
